// File: rtl/be_pkg.sv
// be_pkg: shared types for the RV32I back-end ALU and the arbiter that
// multiplexes requesters onto it.
package be_pkg;

  localparam int ALU_ARB_MAX_REQ = 8;

  typedef logic [31:0] RV32I_OPERAND_t;

  typedef enum logic [5:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    LUI, AUIPC,
    BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR,
    FENCE, ECALL, EBREAK
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef struct packed {
    RV32I_OPERAND_t              a;
    RV32I_OPERAND_t              b;
    RV32I_OPERAND_t              rs1;
    RV32I_OPERAND_t              rs2;
    RV32I_OPERAND_t              imm;
    RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  } ALU_REQ_t;

  typedef enum logic {EMPTY, FULL} ALU_ARB_STATE_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant plus binary index. Round-robin from i_ptr by
// default; RV32I_ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_gnt_idx
);

  logic w_found;

`ifdef RV32I_ALU_ARB_FIXED_PRIO_EN
  logic w_ptr_unused;
  assign w_ptr_unused = ^i_ptr;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_req[k] && !w_found) begin
        o_gnt_idx = ID_W'(k);
        w_found   = 1'b1;
      end
    end
    if (w_found) o_gnt = N'(1) << o_gnt_idx;
  end
`else
  // Rotating a doubled copy puts requester (ptr+k) mod N at bit k.
  logic [2*N-1:0] w_dbl;
  int             w_sum;
  assign w_dbl = {i_req, i_req} >> i_ptr;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = 0;
    for (int k = 0; k < N; k++) begin
      if (w_dbl[k] && !w_found) begin
        w_sum = int'(i_ptr) + k;
        if (w_sum >= N) w_sum = w_sum - N;
        o_gnt_idx = ID_W'(w_sum);
        w_found   = 1'b1;
      end
    end
    if (w_found) o_gnt = N'(1) << o_gnt_idx;
  end
`endif

endmodule

// File: rtl/rv32i_alu.sv
// RV32I_alu: combinational RV32I back-end ALU. Branches report the target
// (a + imm) on o_out and the compare outcome of rs1/rs2 on o_cond_jump.
module RV32I_alu
  import be_pkg::*;
(
  input  ALU_REQ_t    i_op,
  output logic [31:0] o_out,
  output logic        o_cond_jump
);

  always_comb begin
    o_out       = '0;
    o_cond_jump = 1'b0;
    case (i_op.mnemonic)
      ADD:   o_out = i_op.a + i_op.b;
      SUB:   o_out = i_op.a - i_op.b;
      SLL:   o_out = i_op.a << i_op.b[4:0];
      SLT:   o_out = {31'd0, $signed(i_op.a) < $signed(i_op.b)};
      SLTU:  o_out = {31'd0, i_op.a < i_op.b};
      XOR:   o_out = i_op.a ^ i_op.b;
      SRL:   o_out = i_op.a >> i_op.b[4:0];
      SRA:   o_out = $signed(i_op.a) >>> i_op.b[4:0];
      OR:    o_out = i_op.a | i_op.b;
      AND:   o_out = i_op.a & i_op.b;
      ADDI:  o_out = i_op.a + i_op.imm;
      SLTI:  o_out = {31'd0, $signed(i_op.a) < $signed(i_op.imm)};
      SLTIU: o_out = {31'd0, i_op.a < i_op.imm};
      XORI:  o_out = i_op.a ^ i_op.imm;
      ORI:   o_out = i_op.a | i_op.imm;
      ANDI:  o_out = i_op.a & i_op.imm;
      SLLI:  o_out = i_op.a << i_op.imm[4:0];
      SRLI:  o_out = i_op.a >> i_op.imm[4:0];
      SRAI:  o_out = $signed(i_op.a) >>> i_op.imm[4:0];
      LUI:   o_out = i_op.imm;
      AUIPC: o_out = i_op.a + i_op.imm;
      BEQ: begin o_out = i_op.a + i_op.imm; o_cond_jump = (i_op.rs1 == i_op.rs2); end
      BNE: begin o_out = i_op.a + i_op.imm; o_cond_jump = (i_op.rs1 != i_op.rs2); end
      BLT: begin o_out = i_op.a + i_op.imm; o_cond_jump = ($signed(i_op.rs1) <  $signed(i_op.rs2)); end
      BGE: begin o_out = i_op.a + i_op.imm; o_cond_jump = ($signed(i_op.rs1) >= $signed(i_op.rs2)); end
      BLTU: begin o_out = i_op.a + i_op.imm; o_cond_jump = (i_op.rs1 <  i_op.rs2); end
      BGEU: begin o_out = i_op.a + i_op.imm; o_cond_jump = (i_op.rs1 >= i_op.rs2); end
      JAL:  begin o_out = i_op.a + i_op.imm; o_cond_jump = 1'b1; end
      // JALR target clears bit 0 of the computed address
      JALR: begin o_out = (i_op.a + i_op.imm) & ~32'd1; o_cond_jump = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// rv32i_alu_arbiter: shares one RV32I_alu among NUM_REQ requesters with a
// single registered response slot. Define RV32I_ALU_ARB_FIXED_PRIO_EN for fixed priority.
module rv32i_alu_arbiter
  import be_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  ALU_REQ_t [NUM_REQ-1:0]  i_req_op,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [31:0]             o_rsp_out,
  output logic                    o_rsp_cond_jump
);

  ALU_ARB_STATE_t     r_state;
  logic [ID_W-1:0]    r_rsp_id;
  logic [31:0]        r_rsp_out;
  logic               r_rsp_cj;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr;
  logic               w_slot_free;
  logic               w_accept;
  ALU_REQ_t           w_sel;
  logic [31:0]        w_alu_out;
  logic               w_alu_cj;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req     (i_req_valid),
    .i_ptr     (w_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_sel = i_req_op[w_gnt_idx];

  RV32I_alu u_alu (
    .i_op        (w_sel),
    .o_out       (w_alu_out),
    .o_cond_jump (w_alu_cj)
  );

  // The slot can take a new result when empty or when it drains this cycle.
  assign w_slot_free = (r_state == EMPTY) || i_rsp_ready;
  assign o_req_ready = w_slot_free ? w_gnt : '0;
  assign w_accept    = |(i_req_valid & o_req_ready);

`ifdef RV32I_ALU_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [ID_W-1:0] r_rr_ptr;
  assign w_ptr = r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_rsp_id  <= '0;
      r_rsp_out <= '0;
      r_rsp_cj  <= 1'b0;
    end else begin
      if (r_state == EMPTY) begin
        if (w_accept) r_state <= FULL;
      end else begin
        if (!w_accept && i_rsp_ready) r_state <= EMPTY;
      end
      if (w_accept) begin
        r_rsp_id  <= w_gnt_idx;
        r_rsp_out <= w_alu_out;
        r_rsp_cj  <= w_alu_cj;
      end
    end
  end

  assign o_rsp_valid     = (r_state == FULL);
  assign o_rsp_id        = r_rsp_id;
  assign o_rsp_out       = r_rsp_out;
  assign o_rsp_cond_jump = r_rsp_cj;

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// tb_rv32i_alu_arbiter: scoreboard bench for rv32i_alu_arbiter with a
// reference grant/ALU model; directed scenarios followed by random traffic.
module tb_rv32i_alu_arbiter;
  import be_pkg::*;

  localparam int NR = 2;
  localparam int IW = $clog2(NR);

  typedef struct {
    logic [7:0]  id;
    logic        cj;
    logic [31:0] out;
  } sb_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR-1:0]       req_valid;
  ALU_REQ_t [NR-1:0]   req_op;
  logic [NR-1:0]       o_req_ready;
  logic                o_rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       o_rsp_id;
  logic [31:0]         o_rsp_out;
  logic                o_rsp_cond_jump;

  int  n_chk = 0;
  int  n_err = 0;
  sb_t q[$];
  sb_t m_last;
  bit  m_full;
  int  m_ptr;
  RV32I_INSTRUCTION_MNEMONIC_t ops [8] = '{ADD, SUB, XOR, SLT, SRA, BEQ, BNE, ECALL};

  always #5 clk = ~clk;

  rv32i_alu_arbiter #(.NUM_REQ(NR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_valid     (req_valid),
    .i_req_op        (req_op),
    .o_req_ready     (o_req_ready),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_id        (o_rsp_id),
    .o_rsp_out       (o_rsp_out),
    .o_rsp_cond_jump (o_rsp_cond_jump)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ALU_REQ_t mk(input RV32I_INSTRUCTION_MNEMONIC_t mn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm);
    ALU_REQ_t r;
    r.a = a; r.b = b; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.mnemonic = mn;
    return r;
  endfunction

  // Reference results {cond_jump, out} for the mnemonics the bench issues.
  function automatic logic [32:0] malu(input ALU_REQ_t r);
    case (r.mnemonic)
      ADD:     return {1'b0, r.a + r.b};
      SUB:     return {1'b0, r.a - r.b};
      XOR:     return {1'b0, r.a ^ r.b};
      SLT:     return {1'b0, 31'd0, $signed(r.a) < $signed(r.b)};
      SRA:     return {1'b0, $signed(r.a) >>> r.b[4:0]};
      BEQ:     return {r.rs1 == r.rs2, r.a + r.imm};
      BNE:     return {r.rs1 != r.rs2, r.a + r.imm};
      default: return 33'd0;
    endcase
  endfunction

  function automatic int mgrant(input logic [NR-1:0] v, input int p);
    int start;
`ifdef RV32I_ALU_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (start + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check grants against the model, score any consumed response,
  // advance the model, then check the registered slot after the edge.
  task automatic step(input bit hold);
    int            g;
    logic [NR-1:0] erdy;
    logic [32:0]   r;
    sb_t           e;
    #1;
    g    = mgrant(req_valid, m_ptr);
    erdy = '0;
    if ((!m_full || rsp_ready) && g >= 0) erdy[g] = 1'b1;
    chk("req_ready", 64'(o_req_ready), 64'(erdy));
    if (o_rsp_valid && rsp_ready) begin
      chk("sb_occupancy", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_rsp", {8'(o_rsp_id), o_rsp_cond_jump, o_rsp_out}, {e.id, e.cj, e.out});
      end
    end
    if (erdy != '0) begin
      r      = malu(req_op[g]);
      e.id   = 8'(g);
      e.cj   = r[32];
      e.out  = r[31:0];
      q.push_back(e);
      m_last = e;
      m_full = 1'b1;
      m_ptr  = (g + 1) % NR;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
    if (erdy != '0 && !hold) req_valid[g] = 1'b0;
    chk("rsp_valid", 64'(o_rsp_valid), 64'(m_full));
    if (m_full)
      chk("rsp_reg", {8'(o_rsp_id), o_rsp_cond_jump, o_rsp_out}, {m_last.id, m_last.cj, m_last.out});
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_full = 1'b0;
    m_ptr  = 0;
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; rsp_ready = 1'b0;
    m_full = 1'b0; m_ptr = 0;
    repeat (2) @(negedge clk);
    chk("rst_vals", {o_rsp_valid, o_rsp_cond_jump, 8'(o_rsp_id), o_rsp_out}, 64'd0);
    rst_n = 1'b1;
    repeat (10) step(1'b0);
    chk("idle_vals", {o_rsp_cond_jump, 8'(o_rsp_id), o_rsp_out}, 64'd0);

    // single ADD
    rsp_ready = 1'b1;
    req_op[0] = mk(ADD, 32'd5, 32'd7, 0, 0, 0);
    req_valid[0] = 1'b1;
    step(1'b0);
    chk("add_out", {8'(o_rsp_id), o_rsp_out}, {8'd0, 32'd12});
    step(1'b0);

    // contention then backpressure on the SUB
    do_reset();
    req_op[0] = mk(ADD, 32'd5, 32'd7, 0, 0, 0);
    req_op[1] = mk(SUB, 32'd10, 32'd3, 0, 0, 0);
    req_valid = 2'b11;
    step(1'b0);
    chk("c0_out", {8'(o_rsp_id), o_rsp_out}, {8'd0, 32'd12});
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("bp_hold", {8'(o_rsp_id), o_rsp_out}, {8'd0, 32'd12});
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_rdy", 64'(o_req_ready), 64'd2);
    step(1'b0);
    chk("bp_sub", {8'(o_rsp_id), o_rsp_out}, {8'd1, 32'd7});
    step(1'b0);

    // both held continuously: grants alternate 0,1,0,1 with wrap
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) step(1'b1);
    req_valid = '0;
    step(1'b0);
    step(1'b0);

    // branches on requester 1
    req_op[1] = mk(BEQ, 32'h100, 0, 32'h20, 32'h20, 32'h8);
    req_valid[1] = 1'b1;
    step(1'b0);
    chk("beq_taken", {8'(o_rsp_id), o_rsp_cond_jump}, {8'd1, 1'b1});
    req_op[1] = mk(BEQ, 32'h100, 0, 32'h20, 32'h21, 32'h8);
    req_valid[1] = 1'b1;
    step(1'b0);
    chk("beq_not_taken", {8'(o_rsp_id), o_rsp_cond_jump}, {8'd1, 1'b0});

    // undecoded mnemonic still accepted, result zero
    req_op[0] = mk(ECALL, 32'd5, 32'd7, 32'd1, 32'd1, 32'd9);
    req_valid[0] = 1'b1;
    step(1'b0);
    chk("ecall_zero", {o_rsp_valid, o_rsp_cond_jump, o_rsp_out}, {1'b1, 33'd0});
    step(1'b0);

    // random traffic with random backpressure
    for (int c = 0; c < 60; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
          req_op[r] = mk(ops[$urandom_range(0, 7)], $urandom, $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
          req_valid[r] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1'b0);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    // reset while a response is pending and rr_ptr is 1
    req_op[0] = mk(ADD, 32'd1, 32'd2, 0, 0, 0);
    req_valid[0] = 1'b1;
    step(1'b0);
    rsp_ready = 1'b0;
    step(1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 64'(o_rsp_valid), 64'd0);
    m_full = 1'b0; m_ptr = 0; q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_vals", {o_rsp_cond_jump, 8'(o_rsp_id), o_rsp_out}, 64'd0);
    req_op[1] = mk(SUB, 32'd9, 32'd4, 0, 0, 0);
    req_op[0] = mk(ADD, 32'd3, 32'd3, 0, 0, 0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1 chk("rst_grant0", 64'(o_req_ready), 64'd1);
    step(1'b0);
    step(1'b0);
    chk("rst_second", {8'(o_rsp_id), o_rsp_out}, {8'd1, 32'd5});
    step(1'b0);
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
